// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash burst-read sequencer.
// Holds the control/data FSM state enums, the lane-mode enum and the engine read code.
package spi_flash_pkg;

   typedef enum logic [1:0] {IDLE, EX_REQ, EXEC, FSH} REQ_STATE_E;
   typedef enum logic [1:0] {DIDLE, HDR, STREAM, DFSH} DATA_STATE_E;
   typedef enum logic [1:0] {
      LANE_X1  = 2'd0,
      LANE_X2  = 2'd1,
      LANE_X4  = 2'd2,
      LANE_RSV = 2'd3
   } LANE_MODE_E;

   localparam logic [2:0] REQ_CMD_READ = 3'b010;

   // Reserved lane mode falls back to single-lane timing.
   function automatic logic [1:0] lane_shift(input logic [1:0] mode);
      case (LANE_MODE_E'(mode))
         LANE_X2: lane_shift = 2'd1;
         LANE_X4: lane_shift = 2'd2;
         default: lane_shift = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/spi_flash_burst_read_if.sv
// Bus bundle for spi_flash_burst_read: arbiter command, SPI engine and output stream.
// master = the sequencer, slave = its environment (arbiter, engine, consumer).
interface spi_flash_burst_read_if #(
   parameter int NUM_MODULES = 8,
   parameter int DSIZE       = 8,
   parameter int ADDR_BYTES  = 3,
   parameter int LW          = 9
);
   logic                        cmd_request;
   logic [7:0]                  cmd_code;
   logic [NUM_MODULES-1:0]      cmd_busy;
   logic [NUM_MODULES-1:0]      cmd_finish;
   logic [ADDR_BYTES*DSIZE-1:0] rd_addr;
   logic [LW-1:0]               rd_len;
   logic [1:0]                  lane_mode;
   logic                        spi_request;
   logic [23:0]                 spi_req_len;
   logic [23:0]                 spi_req_wr_len;
   logic [2:0]                  spi_req_cmd;
   logic                        spi_busy;
   logic                        spi_wr_ready;
   logic                        spi_clk_en;
   logic                        spi_wr_vld;
   logic [DSIZE-1:0]            spi_wr_data;
   logic                        spi_rd_vld;
   logic [DSIZE-1:0]            spi_rd_data;
   logic                        spi_rd_ready;
   logic                        out_valid;
   logic [DSIZE-1:0]            out_data;
   logic                        out_last;
   logic                        out_ready;
   logic                        err_timeout;

   modport master (
      input  cmd_request, cmd_code, rd_addr, rd_len, lane_mode,
      input  spi_busy, spi_wr_ready, spi_clk_en, spi_rd_vld, spi_rd_data, out_ready,
      output cmd_busy, cmd_finish, spi_request, spi_req_len, spi_req_wr_len, spi_req_cmd,
      output spi_wr_vld, spi_wr_data, spi_rd_ready, out_valid, out_data, out_last, err_timeout
   );

   modport slave (
      output cmd_request, cmd_code, rd_addr, rd_len, lane_mode,
      output spi_busy, spi_wr_ready, spi_clk_en, spi_rd_vld, spi_rd_data, out_ready,
      input  cmd_busy, cmd_finish, spi_request, spi_req_len, spi_req_wr_len, spi_req_cmd,
      input  spi_wr_vld, spi_wr_data, spi_rd_ready, out_valid, out_data, out_last, err_timeout
   );
endinterface

// File: rtl/spi_hdr_mux.sv
// Header byte selector: opcode for the lane mode, address bytes MSB-first, then dummy zeros.
module spi_hdr_mux
   import spi_flash_pkg::*;
#(
   parameter int         DSIZE      = 8,
   parameter int         ADDR_BYTES = 3,
   parameter int         IW         = 3,
   parameter logic [7:0] OPC_X1     = 8'h03,
   parameter logic [7:0] OPC_X2     = 8'h3B,
   parameter logic [7:0] OPC_X4     = 8'h6B
) (
   input  logic [IW-1:0]               i_idx,
   input  logic [1:0]                  i_lane_mode,
   input  logic [ADDR_BYTES*DSIZE-1:0] i_rd_addr,
   output logic [DSIZE-1:0]            o_hdr_byte
);
   logic [DSIZE-1:0] w_addr_byte [ADDR_BYTES];
   logic [DSIZE-1:0] w_opcode;

   genvar gi;
   for (gi = 0; gi < ADDR_BYTES; gi++) begin : g_addr
      assign w_addr_byte[gi] = i_rd_addr[(ADDR_BYTES-1-gi)*DSIZE +: DSIZE];
   end

   always_comb begin
      case (LANE_MODE_E'(i_lane_mode))
         LANE_X2: w_opcode = DSIZE'(OPC_X2);
         LANE_X4: w_opcode = DSIZE'(OPC_X4);
         default: w_opcode = DSIZE'(OPC_X1);
      endcase
   end

   // Indices past the address bytes fall through to the zero dummy bytes.
   always_comb begin
      o_hdr_byte = '0;
      if (i_idx == '0)
         o_hdr_byte = w_opcode;
      for (int k = 0; k < ADDR_BYTES; k++)
         if (i_idx == IW'(k + 1))
            o_hdr_byte = w_addr_byte[k];
   end
endmodule

// File: rtl/spi_flash_burst_read.sv
// Flash burst-read sequencer: requests the SPI engine, sends opcode/address/dummy header, streams data.
// Optional engine-start watchdog enabled by defining SPI_FLASH_RD_TIMEOUT_EN.
module spi_flash_burst_read
   import spi_flash_pkg::*;
#(
   parameter int         MODULE_ID   = 0,
   parameter logic [7:0] CMD         = 8'h00,
   parameter int         NUM_MODULES = 8,
   parameter int         DSIZE       = 8,
   parameter int         ADDR_BYTES  = 3,
   parameter int         DUMMY_BYTES = 0,
   parameter int         MAX_BURST   = 256,
   parameter logic [7:0] OPC_X1      = 8'h03,
   parameter logic [7:0] OPC_X2      = 8'h3B,
   parameter logic [7:0] OPC_X4      = 8'h6B,
   parameter int         TMO_CYCLES  = 1024
) (
   input logic                    clock,
   input logic                    rst_n,
   spi_flash_burst_read_if.master bus
);
   localparam int LW = $clog2(MAX_BURST + 1);
   localparam int HB = 1 + ADDR_BYTES + DUMMY_BYTES;
   localparam int IW = $clog2(HB + 1);

   REQ_STATE_E                  r_req_state;
   DATA_STATE_E                 r_data_state;
   logic                        r_busy, r_finish, r_spi_request, r_err_timeout;
   logic [23:0]                 r_req_len, r_req_wr_len;
   logic [2:0]                  r_req_cmd;
   logic [ADDR_BYTES*DSIZE-1:0] r_addr;
   logic [LW-1:0]               r_len;
   logic [1:0]                  r_lane;
   logic [IW-1:0]               r_idx;
   logic [LW-1:0]               r_cnt;
`ifdef SPI_FLASH_RD_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYCLES + 1);
   logic [TW-1:0]               r_tmo_cnt;
`endif

   logic                        w_trigger, w_stream, w_drop, w_out_valid;
   logic [LW-1:0]               w_len_clamp;
   logic [23:0]                 w_req_len, w_req_wr_len;
   logic [DSIZE-1:0]            w_hdr_byte;

   assign w_trigger = bus.cmd_request && (bus.cmd_code == CMD);

   always_comb begin
      w_len_clamp = bus.rd_len;
      if (bus.rd_len == '0)
         w_len_clamp = LW'(1);
      else if (bus.rd_len > LW'(MAX_BURST))
         w_len_clamp = LW'(MAX_BURST);
   end

   // Header and total clock counts shrink with lane width: 8 bits per byte over 1/2/4 lanes.
   assign w_req_len    = ((24'(HB) + 24'(w_len_clamp)) << 3) >> lane_shift(bus.lane_mode);
   assign w_req_wr_len = 24'(HB * 8) >> lane_shift(bus.lane_mode);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_req_state   <= IDLE;
         r_busy        <= 1'b0;
         r_finish      <= 1'b0;
         r_spi_request <= 1'b0;
         r_err_timeout <= 1'b0;
         r_req_len     <= '0;
         r_req_wr_len  <= '0;
         r_req_cmd     <= '0;
         r_addr        <= '0;
         r_len         <= '0;
         r_lane        <= '0;
`ifdef SPI_FLASH_RD_TIMEOUT_EN
         r_tmo_cnt     <= '0;
`endif
      end else begin
         r_err_timeout <= 1'b0;
         case (r_req_state)
            IDLE: if (w_trigger) begin
               r_req_state   <= EX_REQ;
               r_addr        <= bus.rd_addr;
               r_len         <= w_len_clamp;
               r_lane        <= bus.lane_mode;
               r_req_len     <= w_req_len;
               r_req_wr_len  <= w_req_wr_len;
               r_req_cmd     <= REQ_CMD_READ;
               r_spi_request <= 1'b1;
               r_busy        <= 1'b1;
`ifdef SPI_FLASH_RD_TIMEOUT_EN
               r_tmo_cnt     <= '0;
`endif
            end
            EX_REQ: begin
               if (bus.spi_busy) begin
                  r_req_state   <= EXEC;
                  r_spi_request <= 1'b0;
               end
`ifdef SPI_FLASH_RD_TIMEOUT_EN
               else if (r_tmo_cnt == TW'(TMO_CYCLES - 1)) begin
                  r_req_state   <= FSH;
                  r_spi_request <= 1'b0;
                  r_busy        <= 1'b0;
                  r_finish      <= 1'b1;
                  r_err_timeout <= 1'b1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            EXEC: if (!bus.spi_busy && (r_data_state == DFSH)) begin
               r_req_state <= FSH;
               r_busy      <= 1'b0;
               r_finish    <= 1'b1;
            end
            default: begin
               r_req_state  <= IDLE;
               r_finish     <= 1'b0;
               r_req_len    <= '0;
               r_req_wr_len <= '0;
               r_req_cmd    <= '0;
            end
         endcase
      end
   end

   assign w_stream    = (r_data_state == STREAM);
   assign w_drop      = (r_data_state == DFSH);
   assign w_out_valid = w_stream && bus.spi_rd_vld;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_data_state <= DIDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
      end else begin
         case (r_data_state)
            DIDLE: if (r_req_state == EXEC) begin
               r_data_state <= HDR;
               r_idx        <= '0;
               r_cnt        <= '0;
            end
            HDR: if (bus.spi_wr_ready && bus.spi_clk_en) begin
               if (r_idx == IW'(HB - 1))
                  r_data_state <= STREAM;
               else
                  r_idx <= r_idx + 1'b1;
            end
            STREAM: if (w_out_valid && bus.out_ready) begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == r_len - 1'b1)
                  r_data_state <= DFSH;
            end
            default: if (r_req_state != EXEC)
               r_data_state <= DIDLE;
         endcase
      end
   end

   spi_hdr_mux #(
      .DSIZE      (DSIZE),
      .ADDR_BYTES (ADDR_BYTES),
      .IW         (IW),
      .OPC_X1     (OPC_X1),
      .OPC_X2     (OPC_X2),
      .OPC_X4     (OPC_X4)
   ) u_hdr_mux (
      .i_idx       (r_idx),
      .i_lane_mode (r_lane),
      .i_rd_addr   (r_addr),
      .o_hdr_byte  (w_hdr_byte)
   );

   genvar gi;
   for (gi = 0; gi < NUM_MODULES; gi++) begin : g_arb_bits
      assign bus.cmd_busy[gi]   = (gi == MODULE_ID) ? r_busy   : 1'b0;
      assign bus.cmd_finish[gi] = (gi == MODULE_ID) ? r_finish : 1'b0;
   end

   assign bus.spi_request    = r_spi_request;
   assign bus.spi_req_len    = r_req_len;
   assign bus.spi_req_wr_len = r_req_wr_len;
   assign bus.spi_req_cmd    = r_req_cmd;
   assign bus.spi_wr_vld     = (r_data_state == HDR);
   assign bus.spi_wr_data    = (r_data_state == HDR) ? w_hdr_byte : '0;
   // Once the burst is complete, surplus engine bytes are swallowed rather than stalling the engine.
   assign bus.spi_rd_ready   = (w_stream && bus.out_ready) || w_drop;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_data       = w_out_valid ? bus.spi_rd_data : '0;
   assign bus.out_last       = w_out_valid && (r_cnt == r_len - 1'b1);
`ifdef SPI_FLASH_RD_TIMEOUT_EN
   assign bus.err_timeout    = r_err_timeout;
`else
   assign bus.err_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_spi_flash_burst_read.sv
// Self-checking bench for spi_flash_burst_read with a randomized SPI engine and a reference model.
module tb_spi_flash_burst_read;
   localparam int         MODULE_ID   = 2;
   localparam logic [7:0] CMD         = 8'hA5;
   localparam int         NUM_MODULES = 8;
   localparam int         DSIZE       = 8;
   localparam int         ADDR_BYTES  = 4;
   localparam int         DUMMY_BYTES = 1;
   localparam int         MAX_BURST   = 256;
   localparam int         LW          = $clog2(MAX_BURST + 1);
   localparam int         TMO_CYCLES  = 1024;
   localparam int         HB          = 1 + ADDR_BYTES + DUMMY_BYTES;
   localparam logic [7:0] MY_BIT      = 8'h04;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clock = ~clock;

   spi_flash_burst_read_if #(
      .NUM_MODULES(NUM_MODULES), .DSIZE(DSIZE), .ADDR_BYTES(ADDR_BYTES), .LW(LW)
   ) bus_if ();

   spi_flash_burst_read #(
      .MODULE_ID(MODULE_ID), .CMD(CMD), .NUM_MODULES(NUM_MODULES), .DSIZE(DSIZE),
      .ADDR_BYTES(ADDR_BYTES), .DUMMY_BYTES(DUMMY_BYTES), .MAX_BURST(MAX_BURST),
      .OPC_X1(8'h03), .OPC_X2(8'h3B), .OPC_X4(8'h6B), .TMO_CYCLES(TMO_CYCLES)
   ) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   task automatic drive_idle();
      bus_if.cmd_request  = 1'b0;
      bus_if.cmd_code     = 8'h00;
      bus_if.rd_addr      = '0;
      bus_if.rd_len       = '0;
      bus_if.lane_mode    = 2'd0;
      bus_if.spi_busy     = 1'b0;
      bus_if.spi_wr_ready = 1'b0;
      bus_if.spi_clk_en   = 1'b0;
      bus_if.spi_rd_vld   = 1'b0;
      bus_if.spi_rd_data  = '0;
      bus_if.out_ready    = 1'b0;
   endtask

   task automatic issue_cmd(input logic [31:0] addr, input int len_raw, input logic [1:0] lane);
      @(negedge clock);
      bus_if.cmd_request = 1'b1;
      bus_if.cmd_code    = CMD;
      bus_if.rd_addr     = addr;
      bus_if.rd_len      = LW'(len_raw);
      bus_if.lane_mode   = lane;
      @(negedge clock);
      bus_if.cmd_request = 1'b0;
      bus_if.rd_addr     = $urandom;
      bus_if.rd_len      = LW'($urandom);
      bus_if.lane_mode   = 2'($urandom);
   endtask

   task automatic test_reset();
      logic [31:0] agg;
      repeat (3) @(negedge clock);
      #1;
      agg = {bus_if.cmd_busy, bus_if.cmd_finish, 7'(bus_if.spi_request), bus_if.spi_req_cmd,
             bus_if.spi_wr_vld, bus_if.spi_rd_ready, bus_if.out_valid, bus_if.out_last, bus_if.err_timeout};
      n_checks++;
      if (agg !== 32'h0) $display("FAIL reset_ctrl: got %h, required 0", agg);
      else n_pass++;
      n_checks++;
      if ({bus_if.spi_req_len, bus_if.spi_req_wr_len} !== 48'h0)
         $display("FAIL reset_len: got %h/%h, required 0", bus_if.spi_req_len, bus_if.spi_req_wr_len);
      else n_pass++;
      @(negedge clock);
      rst_n = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      n_checks++;
      if (bus_if.spi_request !== 1'b0 || bus_if.cmd_busy !== 8'h0 || bus_if.out_valid !== 1'b0)
         $display("FAIL post_reset_idle: req=%b busy=%h vld=%b, required 0", bus_if.spi_request, bus_if.cmd_busy, bus_if.out_valid);
      else n_pass++;
      $display("txn reset: outputs sampled in and after reset");
   endtask

   // One complete read against the engine model; the expected header, lengths and stream come from the rules.
   task automatic run_txn(input string name, input logic [31:0] addr, input int len_raw, input logic [1:0] lane,
                          input int n_supply, input bit rand_ready, input int busy_delay, input bit inject_req);
      int          len_eff, ls, sidx, cyc, tail, mirror_err, finish_cnt, finish_bad, drop_cnt, tmo_seen, wait_err, idle_err;
      logic [23:0] exp_len, exp_wr;
      logic [7:0]  opc;
      logic [7:0]  exp_hdr[$];
      logic [7:0]  got_hdr[$];
      logic [7:0]  supply[$];
      logic [7:0]  got_out[$];
      int          last_pos[$];
      bit          done, ok;
      sidx = 0; cyc = 0; tail = 0; mirror_err = 0; finish_cnt = 0; finish_bad = 0;
      drop_cnt = 0; tmo_seen = 0; wait_err = 0; idle_err = 0; done = 1'b0;

      len_eff = (len_raw == 0) ? 1 : ((len_raw > MAX_BURST) ? MAX_BURST : len_raw);
      ls      = (lane == 2'd1) ? 1 : ((lane == 2'd2) ? 2 : 0);
      exp_len = 24'(((HB + len_eff) * 8) >> ls);
      exp_wr  = 24'((HB * 8) >> ls);
      opc     = (lane == 2'd1) ? 8'h3B : ((lane == 2'd2) ? 8'h6B : 8'h03);
      exp_hdr.push_back(opc);
      for (int i = 0; i < ADDR_BYTES; i++) exp_hdr.push_back(addr[8*(ADDR_BYTES-1-i) +: 8]);
      for (int i = 0; i < DUMMY_BYTES; i++) exp_hdr.push_back(8'h00);
      for (int i = 0; i < n_supply; i++) supply.push_back(8'($urandom));

      issue_cmd(addr, len_raw, lane);
      #1;
      n_checks++;
      if (bus_if.spi_request !== 1'b1 || bus_if.cmd_busy !== MY_BIT || bus_if.spi_req_cmd !== 3'b010)
         $display("FAIL %s request: req=%b busy=%h cmd=%b, required 1/%h/010", name, bus_if.spi_request, bus_if.cmd_busy, bus_if.spi_req_cmd, MY_BIT);
      else n_pass++;
      n_checks++;
      if (bus_if.spi_req_len !== exp_len || bus_if.spi_req_wr_len !== exp_wr)
         $display("FAIL %s lengths: got %0d/%0d, required %0d/%0d", name, bus_if.spi_req_len, bus_if.spi_req_wr_len, exp_len, exp_wr);
      else n_pass++;

      for (int i = 0; i < busy_delay; i++) begin
         @(negedge clock);
         #1;
         if (bus_if.spi_request !== 1'b1 || bus_if.spi_req_len !== exp_len) wait_err++;
         if (bus_if.err_timeout !== 1'b0) tmo_seen++;
      end
      @(negedge clock);
      bus_if.spi_busy = 1'b1;

      while (!done && cyc < 3000) begin
         @(negedge clock);
         cyc++;
         bus_if.cmd_request  = inject_req && (cyc == 3 || cyc == 40);
         bus_if.cmd_code     = CMD;
         bus_if.rd_len       = LW'(7);
         bus_if.spi_wr_ready = ($urandom_range(0, 3) != 0);
         bus_if.spi_clk_en   = ($urandom_range(0, 3) != 0);
         bus_if.spi_rd_vld   = (sidx < n_supply) && ($urandom_range(0, 3) != 0);
         bus_if.spi_rd_data  = (sidx < n_supply) ? supply[sidx] : 8'h00;
         bus_if.out_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sidx >= n_supply) bus_if.spi_busy = 1'b0;
         #1;
         if (bus_if.spi_wr_vld && bus_if.spi_wr_ready && bus_if.spi_clk_en) got_hdr.push_back(bus_if.spi_wr_data);
         if (bus_if.out_valid && (bus_if.spi_rd_ready !== bus_if.out_ready)) mirror_err++;
         if (bus_if.out_valid && bus_if.out_ready) begin
            if (bus_if.out_last) last_pos.push_back(got_out.size());
            got_out.push_back(bus_if.out_data);
         end
         if (bus_if.spi_rd_vld && bus_if.spi_rd_ready) begin
            if (!bus_if.out_valid) drop_cnt++;
            sidx++;
         end
         if (bus_if.err_timeout !== 1'b0) tmo_seen++;
         if (bus_if.cmd_finish !== 8'h0) begin
            finish_cnt++;
            if (bus_if.cmd_finish !== MY_BIT) finish_bad++;
         end else if (finish_cnt > 0) begin
            tail++;
            if (bus_if.spi_request !== 1'b0 || bus_if.cmd_busy !== 8'h0 || bus_if.spi_req_len !== 24'h0) idle_err++;
            if (tail == 3) done = 1'b1;
         end
      end
      drive_idle();

      n_checks++;
      if (!done) $display("FAIL %s timeout: transaction incomplete after %0d cycles, required finish", name, cyc);
      else n_pass++;

      ok = (got_hdr.size() == exp_hdr.size());
      for (int i = 0; i < got_hdr.size() && ok; i++) if (got_hdr[i] !== exp_hdr[i]) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL %s header: got %0d bytes (first %h), required %0d bytes (first %h)", name,
                        got_hdr.size(), (got_hdr.size() > 0) ? got_hdr[0] : 8'hxx, exp_hdr.size(), exp_hdr[0]);
      else n_pass++;

      ok = (got_out.size() == len_eff);
      for (int i = 0; i < got_out.size() && ok; i++) if (got_out[i] !== supply[i]) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL %s stream: got %0d bytes, required %0d in order", name, got_out.size(), len_eff);
      else n_pass++;

      n_checks++;
      if (last_pos.size() != 1 || last_pos[0] != len_eff - 1)
         $display("FAIL %s last: got %0d marks (first at %0d), required one at %0d", name, last_pos.size(),
                  (last_pos.size() > 0) ? last_pos[0] : -1, len_eff - 1);
      else n_pass++;

      n_checks++;
      if (mirror_err != 0 || wait_err != 0 || idle_err != 0 || tmo_seen != 0)
         $display("FAIL %s handshake: mirror=%0d wait=%0d idle=%0d tmo=%0d errors, required 0", name, mirror_err, wait_err, idle_err, tmo_seen);
      else n_pass++;

      n_checks++;
      if (finish_cnt != 1 || finish_bad != 0 || drop_cnt != n_supply - len_eff)
         $display("FAIL %s finish: pulses=%0d bad=%0d dropped=%0d, required 1/0/%0d", name, finish_cnt, finish_bad, drop_cnt, n_supply - len_eff);
      else n_pass++;

      $display("txn %s: lane=%0d len=%0d hdr=%0d out=%0d dropped=%0d cycles=%0d", name, lane, len_eff,
               got_hdr.size(), got_out.size(), drop_cnt, cyc);
   endtask

   task automatic test_wrong_cmd();
      int act;
      act = 0;
      @(negedge clock);
      bus_if.cmd_request = 1'b1;
      bus_if.cmd_code    = CMD ^ 8'h01;
      bus_if.rd_len      = LW'(4);
      @(negedge clock);
      bus_if.cmd_request = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (bus_if.spi_request !== 1'b0 || bus_if.cmd_busy !== 8'h0 || bus_if.spi_wr_vld !== 1'b0 || bus_if.spi_req_len !== 24'h0) act++;
         @(negedge clock);
      end
      n_checks++;
      if (act != 0) $display("FAIL wrong_cmd: got %0d active cycles, required 0", act);
      else n_pass++;
      drive_idle();
      $display("txn wrong_cmd: code=%h active_cycles=%0d", CMD ^ 8'h01, act);
   endtask

   task automatic test_reset_mid();
      bit reached;
      int late;
      reached = 1'b0;
      late = 0;
      issue_cmd(32'hCAFE_0001, 8, 2'd0);
      bus_if.spi_busy     = 1'b1;
      bus_if.spi_wr_ready = 1'b1;
      bus_if.spi_clk_en   = 1'b1;
      bus_if.spi_rd_vld   = 1'b1;
      bus_if.spi_rd_data  = 8'h5A;
      bus_if.out_ready    = 1'b0;
      for (int i = 0; i < 50 && !reached; i++) begin
         @(negedge clock);
         #1;
         if (bus_if.out_valid === 1'b1) reached = 1'b1;
      end
      n_checks++;
      if (!reached) $display("FAIL reset_mid_stream: out_valid never seen, required 1 within 50 cycles");
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus_if.out_valid !== 1'b0 || bus_if.spi_rd_ready !== 1'b0 || bus_if.out_data !== 8'h0 || bus_if.cmd_busy !== 8'h0)
         $display("FAIL reset_mid_outputs: vld=%b rdy=%b data=%h busy=%h, required 0", bus_if.out_valid, bus_if.spi_rd_ready, bus_if.out_data, bus_if.cmd_busy);
      else n_pass++;
      n_checks++;
      if (bus_if.spi_req_len !== 24'h0 || bus_if.spi_req_cmd !== 3'b0 || bus_if.spi_wr_vld !== 1'b0 || bus_if.out_last !== 1'b0)
         $display("FAIL reset_mid_engine: len=%0d cmd=%b wvld=%b last=%b, required 0", bus_if.spi_req_len, bus_if.spi_req_cmd, bus_if.spi_wr_vld, bus_if.out_last);
      else n_pass++;
      @(negedge clock);
      rst_n = 1'b1;
      bus_if.spi_busy  = 1'b0;
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         #1;
         if (bus_if.cmd_finish !== 8'h0 || bus_if.out_valid !== 1'b0 || bus_if.spi_request !== 1'b0) late++;
      end
      n_checks++;
      if (late != 0) $display("FAIL reset_mid_no_finish: got %0d active cycles after reset, required 0", late);
      else n_pass++;
      drive_idle();
      $display("txn reset_mid: reached_stream=%0d late_activity=%0d", reached, late);
   endtask

   task automatic test_timeout();
`ifdef SPI_FLASH_RD_TIMEOUT_EN
      int cyc;
      bit seen;
      cyc = 0;
      seen = 1'b0;
      issue_cmd(32'h0000_1000, 4, 2'd0);
      while (!seen && cyc < 1200) begin
         @(negedge clock);
         cyc++;
         #1;
         if (bus_if.err_timeout === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || cyc < TMO_CYCLES - 2 || cyc > TMO_CYCLES + 3)
         $display("FAIL timeout_pulse: seen=%0d after %0d cycles, required near %0d", seen, cyc, TMO_CYCLES);
      else n_pass++;
      n_checks++;
      if (bus_if.spi_request !== 1'b0 || bus_if.cmd_finish !== MY_BIT)
         $display("FAIL timeout_finish: req=%b finish=%h, required 0/%h", bus_if.spi_request, bus_if.cmd_finish, MY_BIT);
      else n_pass++;
      @(negedge clock);
      #1;
      n_checks++;
      if (bus_if.err_timeout !== 1'b0 || bus_if.cmd_finish !== 8'h0)
         $display("FAIL timeout_one_cycle: err=%b finish=%h, required 0/0", bus_if.err_timeout, bus_if.cmd_finish);
      else n_pass++;
      $display("txn timeout: pulse after %0d cycles", cyc);
`else
      run_txn("slow_engine", 32'h0BAD_F00D, 5, 2'd1, 5, 1'b0, 40, 1'b0);
`endif
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++)
         run_txn("random", $urandom, $urandom_range(1, 40), 2'($urandom_range(0, 3)),
                 $urandom_range(40, 44), 1'b1, $urandom_range(0, 3), 1'b0);
   endtask

   initial begin
      drive_idle();
      test_reset();
      run_txn("x1_basic", 32'h0012_3456, 4, 2'd0, 4, 1'b0, 0, 1'b0);
      run_txn("x4_full", 32'hDEAD_BEEF, 256, 2'd2, 256, 1'b0, 2, 1'b0);
      run_txn("x2_backpressure", 32'h89AB_CDEF, 16, 2'd1, 16, 1'b1, 1, 1'b0);
      run_txn("len_zero", 32'h0000_0010, 0, 2'd0, 1, 1'b0, 0, 1'b0);
      run_txn("len_clamp", 32'h7654_3210, 300, 2'd2, 256, 1'b0, 0, 1'b0);
      run_txn("overflow", 32'h1111_2222, 16, 2'd0, 20, 1'b1, 0, 1'b0);
      run_txn("busy_ignore", 32'h3333_4444, 12, 2'd3, 12, 1'b0, 3, 1'b1);
      test_wrong_cmd();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
